// File: rtl/inverter_tester.sv
// Stimulus/checker around the analog inverter: toggles stim_o, times the synchronised response.
// Optional max_delay tracking is built when INVERTER_TESTER_MAXDELAY_EN is defined.
module inverter_tester #(
  parameter int CNT_W       = 16,
  parameter int DLY_W       = 10,
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [CNT_W-1:0] num_edges,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic             resp_i,
  output logic             stim_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [DLY_W-1:0] last_delay,
  output logic [DLY_W-1:0] max_delay
);

  // IDLE wait start | TOGGLE flip stim_o | WAIT time response | SETTLE hold | FINISH report
  typedef enum logic [2:0] {IDLE, TOGGLE, WAIT, SETTLE, FINISH} state_t;

  localparam logic [DLY_W-1:0] TMO = DLY_W'(TIMEOUT);

  state_t           state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rs;
  logic             stim_nx, busy_nx, done_nx, pass_nx;
  logic [ERR_W-1:0] err_nx;
  logic [DLY_W-1:0] last_nx;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic [CNT_W-1:0] settle_cfg, settle_cfg_nx;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_nx;
  logic [DLY_W-1:0] dly_cnt, dly_nx;
  logic             meas_done;
  logic [DLY_W-1:0] meas_val;

  assign rs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sync_q     <= '0;
      stim_o     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      last_delay <= '0;
      remaining  <= '0;
      settle_cfg <= '0;
      settle_cnt <= '0;
      dly_cnt    <= '0;
    end else begin
      state      <= state_nx;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], resp_i};
      stim_o     <= stim_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      err_count  <= err_nx;
      last_delay <= last_nx;
      remaining  <= remaining_nx;
      settle_cfg <= settle_cfg_nx;
      settle_cnt <= settle_cnt_nx;
      dly_cnt    <= dly_nx;
    end
  end

  // dly_cnt holds clock edges elapsed since stim_o changed, so an ideal inverter reads SYNC_STAGES.
  always_comb begin
    state_nx      = state;
    stim_nx       = stim_o;
    busy_nx       = busy;
    done_nx       = 1'b0;
    pass_nx       = pass;
    err_nx        = err_count;
    last_nx       = last_delay;
    remaining_nx  = remaining;
    settle_cfg_nx = settle_cfg;
    settle_cnt_nx = settle_cnt;
    dly_nx        = dly_cnt;
    meas_done     = 1'b0;
    meas_val      = dly_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nx = 1'b1;
          err_nx  = '0;
          if (num_edges != '0) begin
            remaining_nx  = num_edges;
            settle_cfg_nx = settle_cycles;
            state_nx      = TOGGLE;
          end else begin
            state_nx = FINISH;
          end
        end
      end
      TOGGLE: begin
        stim_nx      = ~stim_o;
        dly_nx       = '0;
        remaining_nx = remaining - 1'b1;
        state_nx     = WAIT;
      end
      WAIT: begin
        if (rs == ~stim_o) begin
          meas_done = 1'b1;
          meas_val  = dly_cnt;
        end else if (dly_cnt == TMO) begin
          meas_done = 1'b1;
          meas_val  = TMO;
          if (err_count != '1) err_nx = err_count + 1'b1;
        end else begin
          dly_nx = dly_cnt + 1'b1;
        end
        if (meas_done) begin
          last_nx = meas_val;
          if (settle_cfg != '0) begin
            settle_cnt_nx = settle_cfg;
            state_nx      = SETTLE;
          end else begin
            state_nx = (remaining != '0) ? TOGGLE : FINISH;
          end
        end
      end
      SETTLE: begin
        settle_cnt_nx = settle_cnt - 1'b1;
        if (settle_cnt <= CNT_W'(1)) state_nx = (remaining != '0) ? TOGGLE : FINISH;
      end
      FINISH: begin
        done_nx  = 1'b1;
        pass_nx  = (err_count == '0);
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef INVERTER_TESTER_MAXDELAY_EN
  logic [DLY_W-1:0] max_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                           max_q <= '0;
    else if (state == IDLE && start)        max_q <= '0;
    else if (meas_done && meas_val > max_q) max_q <= meas_val;
  end

  assign max_delay = max_q;
`else
  assign max_delay = '0;
`endif

endmodule

// File: tb/tb_inverter_tester.sv
// Self-checking bench for inverter_tester: behavioural inverter models plus a per-run result model.
module tb_inverter_tester;
  localparam int CNT_W = 16;
  localparam int DLY_W = 10;
  localparam int ERR_W = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_edges = '0;
  logic [CNT_W-1:0] settle_cycles = '0;
  logic             resp_i;
  logic             stim_o, busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [DLY_W-1:0] last_delay, max_delay;

  always #5 clk = ~clk;

  inverter_tester #(.CNT_W(CNT_W), .DLY_W(DLY_W), .ERR_W(ERR_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .num_edges(num_edges),
    .settle_cycles(settle_cycles), .resp_i(resp_i), .stim_o(stim_o), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .last_delay(last_delay), .max_delay(max_delay));

  // inverter models: 0 = combinational, 1 = inv_dly registered cycles, 2 = stuck at stuck_val
  int         mode = 2;
  logic [3:0] inv_dly = 4'd1;
  logic       stuck_val = 1'b1;
  logic [15:0] dline = '0;

  always @(posedge clk) dline <= {dline[14:0], ~stim_o};

  always_comb begin
    resp_i = stuck_val;
    if (mode == 0)      resp_i = ~stim_o;
    else if (mode == 1) resp_i = dline[inv_dly - 4'd1];
  end

  int   toggles = 0, dones = 0;
  logic stim_prev = 1'b0;
  always @(negedge clk) begin
    if (stim_o !== stim_prev) toggles++;
    stim_prev = stim_o;
    if (done === 1'b1) dones++;
  end

  int tests = 0, fails = 0;
  bit exp_stim = 1'b0, exp_pass = 1'b0;
  int exp_last = 0, exp_max = 0, exp_err = 0, exp_len = 0;
  int run_len = 0, tog_base = 0, done_base = 0;
  bit run_ok = 1'b0;

  // delay seen for an edge that drives stim_o to v; -1 means the response never arrives
  function automatic int edge_delay(bit v);
    if (mode == 0) return SYNC;
    if (mode == 1) return int'(inv_dly) + SYNC;
    if (stuck_val == !v) return 0;
    return -1;
  endfunction

  // run length counts cycles from the start cycle to the cycle done is seen high
  task automatic model_run(input int n, input int s);
    exp_err = 0;
    exp_max = 0;
    exp_len = 2;
    for (int i = 0; i < n; i++) begin
      int d;
      exp_stim = !exp_stim;
      d = edge_delay(exp_stim);
      if (d < 0) begin
        d = TMO;
        if (exp_err < 255) exp_err++;
      end
      exp_last = d;
      if (d > exp_max) exp_max = d;
      exp_len += 2 + d + s;
    end
`ifndef INVERTER_TESTER_MAXDELAY_EN
    exp_max = 0;
`endif
    exp_pass = (exp_err == 0);
  endtask

  task automatic do_run(input int n, input int s, input int restart_at);
    num_edges     = 16'(n);
    settle_cycles = 16'(s);
    tog_base  = toggles;
    done_base = dones;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_len = 1;
    while (done !== 1'b1 && run_len < exp_len + 50) begin
      if (run_len == restart_at) begin
        start = 1'b1;
        num_edges = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      run_len++;
    end
    start  = 1'b0;
    run_ok = (done === 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mode = 2; stuck_val = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (stim_o !== 1'b0) begin fails++; $display("FAIL reset stim_o got %b exp 0", stim_o); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done got %b exp 0", done); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL reset pass got %b exp 0", pass); end
    tests++; if (err_count !== '0) begin fails++; $display("FAIL reset err_count got %0d exp 0", err_count); end
    tests++; if (last_delay !== '0) begin fails++; $display("FAIL reset last_delay got %0d exp 0", last_delay); end
    tests++; if (max_delay !== '0) begin fails++; $display("FAIL reset max_delay got %0d exp 0", max_delay); end
    rst = 1'b0;
    exp_stim = 1'b0;
    idle(5);
    tests++; if (busy !== 1'b0 || stim_o !== 1'b0) begin fails++; $display("FAIL reset idle busy/stim got %b/%b exp 0/0", busy, stim_o); end
  endtask

  task automatic test_ideal;
    mode = 0;
    idle(20);
    model_run(4, 3);
    do_run(4, 3, -1);
    tests++; if (!run_ok) begin fails++; $display("FAIL ideal done not seen within %0d cycles", run_len); end
    tests++; if (toggles - tog_base != 4) begin fails++; $display("FAIL ideal toggles got %0d exp 4", toggles - tog_base); end
    tests++; if (dones - done_base != 1) begin fails++; $display("FAIL ideal done pulses got %0d exp 1", dones - done_base); end
    tests++; if (last_delay !== 10'(exp_last)) begin fails++; $display("FAIL ideal last_delay got %0d exp %0d", last_delay, exp_last); end
    tests++; if (max_delay !== 10'(exp_max)) begin fails++; $display("FAIL ideal max_delay got %0d exp %0d", max_delay, exp_max); end
    tests++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL ideal err_count got %0d exp %0d", err_count, exp_err); end
    tests++; if (pass !== exp_pass) begin fails++; $display("FAIL ideal pass got %b exp %b", pass, exp_pass); end
    tests++; if (stim_o !== exp_stim || busy !== 1'b0) begin fails++; $display("FAIL ideal stim/busy got %b/%b exp %b/0", stim_o, busy, exp_stim); end
    tests++; if (run_len != exp_len) begin fails++; $display("FAIL ideal run length got %0d exp %0d", run_len, exp_len); end
  endtask

  task automatic test_delayed;
    mode = 1; inv_dly = 4'd5;
    idle(20);
    model_run(3, 2);
    do_run(3, 2, -1);
    tests++; if (!run_ok) begin fails++; $display("FAIL delayed done not seen within %0d cycles", run_len); end
    tests++; if (last_delay !== 10'(exp_last)) begin fails++; $display("FAIL delayed last_delay got %0d exp %0d", last_delay, exp_last); end
    tests++; if (max_delay !== 10'(exp_max)) begin fails++; $display("FAIL delayed max_delay got %0d exp %0d", max_delay, exp_max); end
    tests++; if (pass !== exp_pass) begin fails++; $display("FAIL delayed pass got %b exp %b", pass, exp_pass); end
    tests++; if (stim_o !== exp_stim) begin fails++; $display("FAIL delayed stim_o got %b exp %b", stim_o, exp_stim); end
    tests++; if (run_len != exp_len) begin fails++; $display("FAIL delayed run length got %0d exp %0d", run_len, exp_len); end
  endtask

  task automatic test_timeout;
    int k;
    mode = 2; stuck_val = 1'b0;
    idle(20);
    model_run(2, 1);
    num_edges = 16'd2; settle_cycles = 16'd1;
    tog_base = toggles; done_base = dones;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (err_count !== 8'd1 && k < TMO + 100) begin @(posedge clk); #1; k++; end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL timeout first err_count got %0d exp 1", err_count); end
    tests++; if (last_delay !== 10'(TMO)) begin fails++; $display("FAIL timeout last_delay got %0d exp %0d", last_delay, TMO); end
    k = 0;
    while (done !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL timeout done not seen within %0d cycles", k); end
    idle(3);
    tests++; if (pass !== exp_pass) begin fails++; $display("FAIL timeout pass got %b exp %b", pass, exp_pass); end
    tests++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL timeout err_count got %0d exp %0d", err_count, exp_err); end
    tests++; if (last_delay !== 10'(exp_last)) begin fails++; $display("FAIL timeout final last_delay got %0d exp %0d", last_delay, exp_last); end
    tests++; if (max_delay !== 10'(exp_max)) begin fails++; $display("FAIL timeout max_delay got %0d exp %0d", max_delay, exp_max); end
    tests++; if (toggles - tog_base != 2) begin fails++; $display("FAIL timeout toggles got %0d exp 2", toggles - tog_base); end
  endtask

  task automatic test_zero_edges;
    model_run(0, 0);
    do_run(0, 0, -1);
    tests++; if (run_len != exp_len) begin fails++; $display("FAIL zero done latency got %0d exp %0d", run_len, exp_len); end
    tests++; if (toggles - tog_base != 0) begin fails++; $display("FAIL zero toggles got %0d exp 0", toggles - tog_base); end
    tests++; if (pass !== 1'b1 || err_count !== '0) begin fails++; $display("FAIL zero pass/err got %b/%0d exp 1/0", pass, err_count); end
    tests++; if (stim_o !== exp_stim) begin fails++; $display("FAIL zero stim_o got %b exp %b", stim_o, exp_stim); end
    tests++; if (dones - done_base != 1) begin fails++; $display("FAIL zero done pulses got %0d exp 1", dones - done_base); end
  endtask

  task automatic test_busy_start;
    mode = 0;
    idle(20);
    model_run(3, 2);
    do_run(3, 2, 4);
    tests++; if (toggles - tog_base != 3) begin fails++; $display("FAIL busy_start toggles got %0d exp 3", toggles - tog_base); end
    tests++; if (run_len != exp_len) begin fails++; $display("FAIL busy_start run length got %0d exp %0d", run_len, exp_len); end
    tests++; if (dones - done_base != 1) begin fails++; $display("FAIL busy_start done pulses got %0d exp 1", dones - done_base); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int n, s;
      mode    = int'($urandom_range(0, 1));
      inv_dly = 4'($urandom_range(1, 8));
      n       = int'($urandom_range(1, 6));
      s       = int'($urandom_range(0, 5));
      idle(20);
      model_run(n, s);
      do_run(n, s, -1);
      tests++; if (last_delay !== 10'(exp_last) || max_delay !== 10'(exp_max)) begin
        fails++; $display("FAIL random[%0d] last/max got %0d/%0d exp %0d/%0d", it, last_delay, max_delay, exp_last, exp_max); end
      tests++; if (err_count !== 8'(exp_err) || pass !== exp_pass) begin
        fails++; $display("FAIL random[%0d] err/pass got %0d/%b exp %0d/%b", it, err_count, pass, exp_err, exp_pass); end
      tests++; if (toggles - tog_base != n || stim_o !== exp_stim) begin
        fails++; $display("FAIL random[%0d] toggles/stim got %0d/%b exp %0d/%b", it, toggles - tog_base, stim_o, n, exp_stim); end
      tests++; if (run_len != exp_len) begin fails++; $display("FAIL random[%0d] run length got %0d exp %0d", it, run_len, exp_len); end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    mode = 1; inv_dly = 4'd5;
    idle(20);
    if (!exp_stim) begin
      model_run(1, 0);
      do_run(1, 0, -1);
    end
    num_edges = 16'd4; settle_cycles = 16'd0;
    tog_base = toggles; done_base = dones;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (toggles - tog_base < 2 && k < 200) begin @(posedge clk); #1; k++; end
    tests++; if (toggles - tog_base != 2) begin fails++; $display("FAIL reset_mid second edge got %0d toggles exp 2", toggles - tog_base); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (stim_o !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_mid stim/busy got %b/%b exp 0/0", stim_o, busy); end
    rst = 1'b0;
    exp_stim = 1'b0;
    idle(10);
    tests++; if (dones != done_base) begin fails++; $display("FAIL reset_mid done pulses got %0d exp 0", dones - done_base); end
    mode = 0;
    idle(20);
    model_run(4, 1);
    do_run(4, 1, -1);
    tests++; if (toggles - tog_base != 4 || stim_o !== exp_stim) begin
      fails++; $display("FAIL reset_mid rerun toggles/stim got %0d/%b exp 4/%b", toggles - tog_base, stim_o, exp_stim); end
    tests++; if (last_delay !== 10'(exp_last) || pass !== exp_pass) begin
      fails++; $display("FAIL reset_mid rerun last/pass got %0d/%b exp %0d/%b", last_delay, pass, exp_last, exp_pass); end
    tests++; if (dones - done_base != 1 || run_len != exp_len) begin
      fails++; $display("FAIL reset_mid rerun dones/len got %0d/%0d exp 1/%0d", dones - done_base, run_len, exp_len); end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_delayed;
    test_timeout;
    test_zero_edges;
    test_busy_start;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached after %0d tests", tests);
    $fatal(1);
  end

endmodule
